euler_step_engine: RTL and testbench
====================================

// Module: euler_step_engine
// PURPOSE
//  Responder side of the Euler_Enable/Euler_End handshake driven by the step-size controller.
//  On each request it performs one explicit Euler step of dx/dt = A*x on the shared RAM:
//  X_process[i] = X_init[i] + h*sum_j(A[i][j]*X_init[j]), with h read from Htemp.
//  It shares the RAM coordinator's two read ports and one write port with the controller.
//  Data is signed 16-bit fixed point, held in bits [15:0] of each 64-bit RAM word.
// PARAMETERS
//  ADDRESS_WIDTH  13   RAM address width
//  DATA_WIDTH     64   RAM word width
//  FRAC_BITS      10   fractional bits of the Q format (1.0 = 1024)
//  N_MAX          50   maximum number of state variables
//  N_ADD          0    address of N
//  HTEMP_ADD      4    address of current step size h
//  X_PROCESS_ADD  6    base of output vector X_process[0..N-1]
//  X_INIT_ADD     56   base of input vector X_init[0..N-1]
//  A_BASE         156  base of matrix A, row-major, A[i][j] at A_BASE + i*N + j
// PORTS
//  CLK                    in   1   clock, rising edge
//  RST                    in   1   synchronous reset, active-high
//  Euler_Enable           in   1   step request from controller, level, held until Euler_End seen
//  Euler_End              out  1   one-cycle pulse: step complete, all writes done
//  Euler_Overflow         out  1   sticky saturation/N-range flag for the current step
//  Euler_Mem_WR_Enable    out  1   RAM write strobe
//  RAM_Address_RD_A       out  13  read address, port A (A matrix / scalars)
//  RAM_Address_RD_B       out  13  read address, port B (X_init)
//  RAM_Data_RD_A          in   64  port A read data, valid one cycle after address
//  RAM_Data_RD_B          in   64  port B read data, valid one cycle after address
//  RAM_Address_WR         out  13  write address
//  RAM_Data_WR            out  64  write data, [15:0] result, [63:16] sign extension
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; internal i, j, row_base, acc, h and N cleared.
//  Reset mid-step aborts the step. No write and no Euler_End are produced.
//  All outputs are registered. Write takes effect in the cycle WR_Enable is high.
//  IDLE: Euler_Enable=1 -> LOAD.
//  LOAD: RD_A=N_ADD, RD_B=HTEMP_ADD. Clear Euler_Overflow. -> CAPTURE.
//  CAPTURE: latch N=RD_A[12:0] and h=RD_B[15:0]; i=j=row_base=0.
//    If N>N_MAX, use N=N_MAX and set Overflow.
//    If N==0 -> DONE. Else -> ADDR.
//  ADDR: RD_A=A_BASE+row_base+j, RD_B=X_INIT_ADD+j. -> MAC.
//  MAC: acc += (A*x)>>>FRAC_BITS, with a 32-bit product and a 32-bit signed accumulator.
//    j++. If j==N -> XADDR, else -> ADDR.
//  XADDR: RD_B=X_INIT_ADD+i; acc_s = sat16(acc). -> WRITE.
//  WRITE: res = sat16(x_i + (h*acc_s)>>>FRAC_BITS); WR_Enable=1; WR addr=X_PROCESS_ADD+i.
//    row_base+=N; i++; j=0; acc=0.
//    If i==N -> DONE, else -> ADDR.
//    WR_Enable returns to 0 in the next cycle.
//  DONE: Euler_End=1 for exactly one cycle. -> WAIT_LOW.
//  WAIT_LOW: hold until Euler_Enable==0, then -> IDLE. A held-high Enable never restarts a step.
//  Euler_Enable dropping mid-step is ignored: the step completes and End is still pulsed.
//  Latency: Euler_End is high in cycle 3+N*(2N+2), counted from the edge that first samples
//    Enable=1 as cycle 0. N=0 gives 3.
//  Arithmetic:
//    >>> is an arithmetic shift (floor).
//    sat16 clamps to [-32768, 32767] and sets Euler_Overflow whenever it clamps.
//    Overflow stays set until the next LOAD.
//  Never writes addresses outside X_PROCESS_ADD..X_PROCESS_ADD+N-1.
//  Never writes N, h, X_init or A.
// TESTING (FRAC_BITS=10)
//  1. N=1, A=[-1024], X_init=[1024], h=512
//     -> one write: addr 6, data 512. End at cycle 7. Overflow=0.
//  2. N=2, A=[[0,1024],[-1024,0]], X_init=[1024,0], h=256
//     -> writes: addr 6 data 1024, addr 7 data 0xFF..FF00 (-256). End at cycle 15.
//  3. N=1, A=[1024], X_init=[30720], h=1024
//     -> addr 6 data 32767, Overflow=1.
//     Overflow clears at LOAD of the next request.
//  4. N=0 -> no write strobe. End at cycle 3. Then Enable held high 10 cycles -> no second End.
//  5. RST=1 during MAC of row 1 (N=2)
//     -> all outputs 0 next cycle, no row-1 write, no End.
//     A new request then completes normally.
//  6. N=60 (>N_MAX) -> Overflow=1. Exactly 50 writes (addresses 6..55). End pulsed once.

Source files
------------

// File: rtl/euler_step_engine_if.sv
// rtl/euler_step_engine_if.sv - Euler step handshake and shared RAM port bundle
// Ports (signals):
//   Euler_Enable         step request from controller (level)
//   Euler_End            one-cycle step-complete pulse
//   Euler_Overflow       sticky saturation / N-range flag
//   Euler_Mem_WR_Enable  RAM write strobe
//   RAM_Address_RD_A/B   read addresses, RAM_Data_RD_A/B read data (one cycle later)
//   RAM_Address_WR       write address, RAM_Data_WR write data
// master: controller / RAM coordinator side; slave: the Euler engine.
interface euler_step_engine_if #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64
);
  logic                     Euler_Enable;
  logic                     Euler_End;
  logic                     Euler_Overflow;
  logic                     Euler_Mem_WR_Enable;
  logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_A;
  logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_B;
  logic [DATA_WIDTH-1:0]    RAM_Data_RD_A;
  logic [DATA_WIDTH-1:0]    RAM_Data_RD_B;
  logic [ADDRESS_WIDTH-1:0] RAM_Address_WR;
  logic [DATA_WIDTH-1:0]    RAM_Data_WR;

  modport master (
    output Euler_Enable, RAM_Data_RD_A, RAM_Data_RD_B,
    input  Euler_End, Euler_Overflow, Euler_Mem_WR_Enable,
    input  RAM_Address_RD_A, RAM_Address_RD_B, RAM_Address_WR, RAM_Data_WR
  );

  modport slave (
    input  Euler_Enable, RAM_Data_RD_A, RAM_Data_RD_B,
    output Euler_End, Euler_Overflow, Euler_Mem_WR_Enable,
    output RAM_Address_RD_A, RAM_Address_RD_B, RAM_Address_WR, RAM_Data_WR
  );
endinterface

// File: rtl/euler_step_engine.sv
// rtl/euler_step_engine.sv - one explicit Euler step X_process = X_init + h*A*X_init on shared RAM
// Ports:
//   CLK  clock, rising edge
//   RST  synchronous reset, active-high
//   bus  euler_step_engine_if.slave: Enable/End handshake, Overflow flag,
//        two read ports (A: matrix/scalars, B: X_init) and one write port
// Data is signed Q(16-FRAC_BITS).FRAC_BITS in bits [15:0] of each RAM word.
module euler_step_engine #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int FRAC_BITS     = 10,
  parameter int N_MAX         = 50,
  parameter int N_ADD         = 0,
  parameter int HTEMP_ADD     = 4,
  parameter int X_PROCESS_ADD = 6,
  parameter int X_INIT_ADD    = 56,
  parameter int A_BASE        = 156
) (
  input logic               CLK,
  input logic               RST,
  euler_step_engine_if.slave bus
);
  localparam int AW = ADDRESS_WIDTH;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD     = 4'd1;
  localparam logic [3:0] S_CAPTURE  = 4'd2;
  localparam logic [3:0] S_ADDR     = 4'd3;
  localparam logic [3:0] S_MAC      = 4'd4;
  localparam logic [3:0] S_XADDR    = 4'd5;
  localparam logic [3:0] S_WRITE    = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_WAIT_LOW = 4'd8;

  localparam logic [AW-1:0] ONE_W    = AW'(1);
  localparam logic [AW-1:0] N_MAX_W  = AW'(N_MAX);
  localparam logic [AW-1:0] N_ADD_W  = AW'(N_ADD);
  localparam logic [AW-1:0] H_ADD_W  = AW'(HTEMP_ADD);
  localparam logic [AW-1:0] X_PROC_W = AW'(X_PROCESS_ADD);
  localparam logic [AW-1:0] X_INIT_W = AW'(X_INIT_ADD);
  localparam logic [AW-1:0] A_BASE_W = AW'(A_BASE);

  logic [3:0]         state;
  logic [AW-1:0]      n_reg;
  logic [AW-1:0]      i_reg;
  logic [AW-1:0]      j_reg;
  logic [AW-1:0]      row_base;
  logic signed [31:0] acc;
  logic signed [15:0] h_reg;
  logic signed [15:0] acc_s;

  // {clipped, value}: clamp to the signed 16-bit range
  function automatic logic [16:0] sat16(input logic signed [32:0] v);
    if (v > 33'sd32767)
      return {1'b1, 16'h7fff};
    else if (v < -33'sd32768)
      return {1'b1, 16'h8000};
    else
      return {1'b0, v[15:0]};
  endfunction

  logic signed [15:0] a_val;
  logic signed [15:0] x_val;
  logic signed [31:0] prod;
  logic signed [31:0] mac_sum;
  logic signed [31:0] h_prod;
  logic signed [32:0] w_sum;
  logic [16:0]        acc_sat;
  logic [16:0]        res_sat;
  logic [AW-1:0]      n_rd;
  logic [AW-1:0]      j_inc;
  logic [AW-1:0]      i_inc;

  always_comb begin
    a_val   = bus.RAM_Data_RD_A[15:0];
    x_val   = bus.RAM_Data_RD_B[15:0];
    n_rd    = bus.RAM_Data_RD_A[AW-1:0];
    prod    = 32'(a_val) * 32'(x_val);
    // 32-bit accumulator wraps; only the final per-row value is saturated
    mac_sum = acc + (prod >>> FRAC_BITS);
    acc_sat = sat16({acc[31], acc});
    h_prod  = 32'(h_reg) * 32'(acc_s);
    w_sum   = 33'(x_val) + 33'(h_prod >>> FRAC_BITS);
    res_sat = sat16(w_sum);
    j_inc   = j_reg + ONE_W;
    i_inc   = i_reg + ONE_W;
  end

  // Upper word bits carry only sign extension and are not needed
  logic unused_rd_bits;
  assign unused_rd_bits = ^{bus.RAM_Data_RD_A[DATA_WIDTH-1:16], bus.RAM_Data_RD_B[DATA_WIDTH-1:16]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state                   <= S_IDLE;
      n_reg                   <= '0;
      i_reg                   <= '0;
      j_reg                   <= '0;
      row_base                <= '0;
      acc                     <= '0;
      acc_s                   <= '0;
      h_reg                   <= '0;
      bus.Euler_End           <= 1'b0;
      bus.Euler_Overflow      <= 1'b0;
      bus.Euler_Mem_WR_Enable <= 1'b0;
      bus.RAM_Address_RD_A    <= '0;
      bus.RAM_Address_RD_B    <= '0;
      bus.RAM_Address_WR      <= '0;
      bus.RAM_Data_WR         <= '0;
    end else begin
      bus.Euler_End           <= 1'b0;
      bus.Euler_Mem_WR_Enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.Euler_Enable) state <= S_LOAD;
        end
        S_LOAD: begin
          bus.RAM_Address_RD_A <= N_ADD_W;
          bus.RAM_Address_RD_B <= H_ADD_W;
          bus.Euler_Overflow   <= 1'b0;
          state                <= S_CAPTURE;
        end
        S_CAPTURE: begin
          h_reg    <= bus.RAM_Data_RD_B[15:0];
          i_reg    <= '0;
          j_reg    <= '0;
          row_base <= '0;
          acc      <= '0;
          if (n_rd > N_MAX_W) begin
            n_reg              <= N_MAX_W;
            bus.Euler_Overflow <= 1'b1;
            state              <= S_ADDR;
          end else begin
            n_reg <= n_rd;
            state <= (n_rd == '0) ? S_DONE : S_ADDR;
          end
        end
        S_ADDR: begin
          bus.RAM_Address_RD_A <= A_BASE_W + row_base + j_reg;
          bus.RAM_Address_RD_B <= X_INIT_W + j_reg;
          state                <= S_MAC;
        end
        S_MAC: begin
          acc   <= mac_sum;
          j_reg <= j_inc;
          state <= (j_inc == n_reg) ? S_XADDR : S_ADDR;
        end
        S_XADDR: begin
          bus.RAM_Address_RD_B <= X_INIT_W + i_reg;
          acc_s                <= acc_sat[15:0];
          if (acc_sat[16]) bus.Euler_Overflow <= 1'b1;
          state                <= S_WRITE;
        end
        S_WRITE: begin
          bus.Euler_Mem_WR_Enable <= 1'b1;
          bus.RAM_Address_WR      <= X_PROC_W + i_reg;
          bus.RAM_Data_WR         <= {{(DATA_WIDTH-16){res_sat[15]}}, res_sat[15:0]};
          if (res_sat[16]) bus.Euler_Overflow <= 1'b1;
          row_base                <= row_base + n_reg;
          i_reg                   <= i_inc;
          j_reg                   <= '0;
          acc                     <= '0;
          state                   <= (i_inc == n_reg) ? S_DONE : S_ADDR;
        end
        S_DONE: begin
          bus.Euler_End <= 1'b1;
          state         <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          // a held-high request must not start another step
          if (!bus.Euler_Enable) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_euler_step_engine.sv
// tb/tb_euler_step_engine.sv - self-checking bench for euler_step_engine
module tb_euler_step_engine;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  euler_step_engine_if bus ();
  euler_step_engine dut (.CLK(CLK), .RST(RST), .bus(bus));

  logic [63:0] mem [8192];
  assign bus.RAM_Data_RD_A = mem[bus.RAM_Address_RD_A];
  assign bus.RAM_Data_RD_B = mem[bus.RAM_Address_RD_B];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          wr_addr_q[$];
  logic [63:0] wr_data_q[$];
  int          end_cnt = 0;
  int          end_cyc = 0;
  logic        end_ovf = 1'b0;

  always @(negedge CLK) begin
    if (bus.Euler_Mem_WR_Enable === 1'b1) begin
      wr_addr_q.push_back(int'(bus.RAM_Address_WR));
      wr_data_q.push_back(bus.RAM_Data_WR);
    end
    if (bus.Euler_End === 1'b1) begin
      end_cnt = end_cnt + 1;
      end_cyc = cyc;
      end_ovf = bus.Euler_Overflow;
    end
  end

  int          a_m[2500];
  int          x_m[50];
  int          h_v;
  int          exp_addr[$];
  logic [63:0] exp_data[$];
  bit          exp_ovf;
  int          exp_n;
  int          lat;
  logic        ovf_load;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx(input int v);
    logic [15:0] t;
    t = v[15:0];
    return {{48{t[15]}}, t};
  endfunction

  function automatic int sat(input longint v);
    if (v > 32767) begin exp_ovf = 1'b1; return 32767; end
    if (v < -32768) begin exp_ovf = 1'b1; return -32768; end
    return int'(v);
  endfunction

  task automatic load_mem(input int n_raw);
    int n;
    n = (n_raw > 50) ? 50 : n_raw;
    mem[0] = 64'(n_raw);
    mem[4] = sx(h_v);
    for (int j = 0; j < n; j++) mem[56 + j] = sx(x_m[j]);
    for (int k = 0; k < n * n; k++) mem[156 + k] = sx(a_m[k]);
  endtask

  // Reference: plain integer evaluation of x + h*(A*x) with the Q-format rules
  task automatic build_expect(input int n_raw);
    int n, acc, accs, res;
    exp_addr.delete();
    exp_data.delete();
    exp_ovf = 1'b0;
    n = n_raw;
    if (n_raw > 50) begin n = 50; exp_ovf = 1'b1; end
    exp_n = n;
    for (int i = 0; i < n; i++) begin
      acc = 0;
      for (int j = 0; j < n; j++) acc = acc + ((a_m[i * n + j] * x_m[j]) >>> 10);
      accs = sat(longint'(acc));
      res  = sat(longint'(x_m[i]) + longint'((h_v * accs) >>> 10));
      exp_addr.push_back(6 + i);
      exp_data.push_back(sx(res));
    end
  endtask

  task automatic run_step(input int hold);
    int start, budget;
    wr_addr_q.delete();
    wr_data_q.delete();
    end_cnt = 0;
    start = cyc + 1;
    bus.Euler_Enable = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    ovf_load = bus.Euler_Overflow;
    budget = 0;
    while (end_cnt == 0 && budget < 20000) begin
      @(negedge CLK);
      budget++;
    end
    lat = end_cyc - start;
    repeat (hold) @(negedge CLK);
    bus.Euler_Enable = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_step(input string tag);
    chk({tag, "_end_count"}, 64'(end_cnt), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(3 + exp_n * (2 * exp_n + 2)));
    chk({tag, "_overflow"}, 64'(end_ovf), 64'(exp_ovf));
    chk({tag, "_ovf_clear_at_load"}, 64'(ovf_load), 64'd0);
    chk({tag, "_write_count"}, 64'(wr_addr_q.size()), 64'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size(); k++) begin
      if (k < wr_addr_q.size()) begin
        chk({tag, "_wr_addr"}, 64'(wr_addr_q[k]), 64'(exp_addr[k]));
        chk({tag, "_wr_data"}, wr_data_q[k], exp_data[k]);
      end
    end
  endtask

  task automatic set_case2();
    h_v = 256;
    x_m[0] = 1024; x_m[1] = 0;
    a_m[0] = 0; a_m[1] = 1024; a_m[2] = -1024; a_m[3] = 0;
    load_mem(2);
    build_expect(2);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 8192; k++) mem[k] = '0;
    RST = 1'b1;
    bus.Euler_Enable = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {bus.Euler_End, bus.Euler_Overflow, bus.Euler_Mem_WR_Enable,
        bus.RAM_Address_RD_A, bus.RAM_Address_RD_B, bus.RAM_Address_WR} === '0, 1'b1);
    chk("reset_wr_data", bus.RAM_Data_WR, 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    // 1: single decaying state
    h_v = 512; x_m[0] = 1024; a_m[0] = -1024;
    load_mem(1); build_expect(1);
    run_step(0);
    check_step("t1");
    if (wr_data_q.size() > 0) chk("t1_hand_data", wr_data_q[0], 64'd512);

    // 2: rotation matrix
    set_case2();
    run_step(0);
    check_step("t2");
    if (wr_data_q.size() > 1) chk("t2_hand_data1", wr_data_q[1], 64'hFFFF_FFFF_FFFF_FF00);

    // 3: saturation
    h_v = 1024; x_m[0] = 30720; a_m[0] = 1024;
    load_mem(1); build_expect(1);
    run_step(0);
    check_step("t3");
    chk("t3_hand_ovf", 64'(end_ovf), 64'd1);

    // 4: N=0, then Enable held high after End
    load_mem(0); build_expect(0);
    run_step(10);
    check_step("t4");

    // randomized steps
    for (int r = 0; r < 5; r++) begin
      n = int'($urandom_range(1, 6));
      h_v = int'($urandom_range(0, 2048));
      for (int j = 0; j < n; j++)
        x_m[j] = (r % 2 == 0) ? int'($urandom_range(0, 65535)) - 32768
                              : int'($urandom_range(0, 8192)) - 4096;
      for (int k = 0; k < n * n; k++) a_m[k] = int'($urandom_range(0, 4096)) - 2048;
      load_mem(n); build_expect(n);
      run_step(int'($urandom_range(0, 3)));
      check_step("rand");
    end

    // 5: reset during MAC of row 1
    set_case2();
    wr_addr_q.delete(); wr_data_q.delete(); end_cnt = 0;
    bus.Euler_Enable = 1'b1;
    repeat (10) @(negedge CLK);
    chk("t5_row0_written", 64'(wr_addr_q.size()), 64'd1);
    RST = 1'b1;
    bus.Euler_Enable = 1'b0;
    @(negedge CLK);
    chk("t5_reset_outputs", {bus.Euler_End, bus.Euler_Overflow, bus.Euler_Mem_WR_Enable,
        bus.RAM_Address_RD_A, bus.RAM_Address_RD_B, bus.RAM_Address_WR} === '0, 1'b1);
    chk("t5_reset_wr_data", bus.RAM_Data_WR, 64'd0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    chk("t5_no_row1_write", 64'(wr_addr_q.size()), 64'd1);
    chk("t5_no_end", 64'(end_cnt), 64'd0);
    set_case2();
    run_step(0);
    check_step("t5_after");

    // 6: N beyond N_MAX
    h_v = int'($urandom_range(0, 1024));
    for (int j = 0; j < 50; j++) x_m[j] = int'($urandom_range(0, 4096)) - 2048;
    for (int k = 0; k < 2500; k++) a_m[k] = int'($urandom_range(0, 256)) - 128;
    load_mem(60); build_expect(60);
    run_step(0);
    check_step("t6");
    chk("t6_hand_writes", 64'(wr_addr_q.size()), 64'd50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
